// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the data memory controller: RV32 load/store width
// codes, the controller FSM state type and the widths of the byte/halfword
// lane-select fields taken from the low address bits.
// -----------------------------------------------------------------------------
package data_mem_pkg;

  // RV32 funct3 width codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte lane select is addr[1:0]; halfword select is addr[1]
  localparam int LANE_SEL_W = 2;
  localparam int HALF_SEL_W = 1;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage : data_mem_pkg

// File: rtl/data_mem_align.sv
// -----------------------------------------------------------------------------
// data_mem_align
// Purely combinational lane logic for the data memory controller.
//   i_we        : 1 = store, 0 = load
//   i_funct3    : RV32 width code
//   i_lane      : byte address bits [1:0]
//   i_wdata     : right-aligned store data
//   i_rword     : addressed memory word (for loads)
//   o_be        : per-byte write enables (zero when misaligned/illegal)
//   o_wdata_rep : store data replicated across all lanes
//   o_load_data : selected lane, sign- or zero-extended to 32 bits
//   o_misalign  : halfword on odd address, or word not on a 4-byte boundary
//   o_illegal   : funct3 code not valid for the access direction
// -----------------------------------------------------------------------------
module data_mem_align
  import data_mem_pkg::*;
(
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [LANE_SEL_W-1:0] i_lane,
  input  logic [31:0]           i_wdata,
  input  logic [31:0]           i_rword,
  output logic [3:0]            o_be,
  output logic [31:0]           o_wdata_rep,
  output logic [31:0]           o_load_data,
  output logic                  o_misalign,
  output logic                  o_illegal
);

  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [HALF_SEL_W-1:0] w_half_sel;
  logic [3:0]            w_be_raw;

  assign w_half_sel = i_lane[1];

  // Select the addressed byte and halfword out of the memory word
  always_comb begin
    w_byte = 8'h00;
    case (i_lane)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      2'd3:    w_byte = i_rword[31:24];
      default: w_byte = 8'h00;
    endcase
    if (w_half_sel == 1'b1) begin
      w_half = i_rword[31:16];
    end else begin
      w_half = i_rword[15:0];
    end
  end

  // Decode width code into enables, replicated data, extended load and flags
  always_comb begin
    w_be_raw    = 4'b0000;
    o_wdata_rep = 32'h0000_0000;
    o_load_data = 32'h0000_0000;
    o_misalign  = 1'b0;
    o_illegal   = 1'b0;
    case (i_funct3)
      F3_B: begin
        w_be_raw    = 4'b0001 << i_lane;
        o_wdata_rep = {4{i_wdata[7:0]}};
        o_load_data = {{24{w_byte[7]}}, w_byte};
      end
      F3_H: begin
        w_be_raw    = (w_half_sel == 1'b1) ? 4'b1100 : 4'b0011;
        o_wdata_rep = {2{i_wdata[15:0]}};
        o_load_data = {{16{w_half[15]}}, w_half};
        o_misalign  = i_lane[0];
      end
      F3_W: begin
        w_be_raw    = 4'b1111;
        o_wdata_rep = i_wdata;
        o_load_data = i_rword;
        o_misalign  = |i_lane;
      end
      F3_BU: begin
        o_load_data = {24'h00_0000, w_byte};
        o_illegal   = i_we;          // no unsigned store form
      end
      F3_HU: begin
        o_load_data = {16'h0000, w_half};
        o_misalign  = i_lane[0];
        o_illegal   = i_we;
      end
      default: begin
        o_illegal   = 1'b1;
      end
    endcase
  end

  // A faulting access never produces byte enables
  assign o_be = w_be_raw & {4{~(o_misalign | o_illegal)}};

endmodule : data_mem_align

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Word-organised data memory with an RV32 load/store request/response port and
// a programmable number of wait states.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake
//   req_we, req_funct3    : store/load and width code
//   req_addr, req_wdata   : byte address, right-aligned store data
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata, rsp_err    : extended load data (0 for stores/errors), fault flag
// The access itself (store commit / load sample) happens on the edge that
// enters RESP; rsp_valid follows on the next edge, so the response appears
// WAIT_STATES+1 cycles after acceptance.
// -----------------------------------------------------------------------------
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_SIZE    = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int         IDX_W = $clog2(MEM_SIZE);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  // Registers
  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_rsp_valid;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  r_rst_done;
  logic [31:0]           r_mem [MEM_SIZE];

  // Wires
  state_t                w_state_nxt;
  logic [3:0]            w_cnt_nxt;
  logic                  w_accept;
  logic                  w_rsp_done;
  logic                  w_enter_resp;
  logic                  w_op_we;
  logic [2:0]            w_op_funct3;
  logic [ADDR_WIDTH-1:0] w_op_addr;
  logic [31:0]           w_op_wdata;
  logic [IDX_W-1:0]      w_idx;
  logic [31:0]           w_rword;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_rep;
  logic [31:0]           w_load_data;
  logic                  w_misalign;
  logic                  w_illegal;
  logic                  w_oob;
  logic                  w_err;

  // Handshake: consumer takes the response only while it is actually shown;
  // r_rst_done keeps req_ready low until the first edge after reset release.
  always_comb begin
    w_rsp_done = (r_state == ST_RESP) && r_rsp_valid && rsp_ready;
    if (r_rst_done) begin
      req_ready = (r_state == ST_IDLE) || w_rsp_done;
    end else begin
      req_ready = 1'b0;
    end
    w_accept = req_valid && req_ready;
  end

  // With zero wait states the access happens on the acceptance edge itself,
  // so the operation must come straight from the inputs in that case.
  always_comb begin
    if (w_accept) begin
      w_op_we     = req_we;
      w_op_funct3 = req_funct3;
      w_op_addr   = req_addr;
      w_op_wdata  = req_wdata;
    end else begin
      w_op_we     = r_we;
      w_op_funct3 = r_funct3;
      w_op_addr   = r_addr;
      w_op_wdata  = r_wdata;
    end
  end

  assign w_idx   = w_op_addr[IDX_W+1:2];
  assign w_rword = r_mem[w_idx];

  // Any set bit above the word index means beyond the array: no wrap-around
  if (ADDR_WIDTH > IDX_W + 2) begin : g_oob
    assign w_oob = |w_op_addr[ADDR_WIDTH-1:IDX_W+2];
  end else begin : g_no_oob
    assign w_oob = 1'b0;
  end

  data_mem_align u_align (
    .i_we        (w_op_we),
    .i_funct3    (w_op_funct3),
    .i_lane      (w_op_addr[LANE_SEL_W-1:0]),
    .i_wdata     (w_op_wdata),
    .i_rword     (w_rword),
    .o_be        (w_be),
    .o_wdata_rep (w_wdata_rep),
    .o_load_data (w_load_data),
    .o_misalign  (w_misalign),
    .o_illegal   (w_illegal)
  );

  assign w_err = w_misalign | w_illegal | w_oob;

  // FSM next state, wait-counter update and access strobe
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_accept) begin
          if (WS != 4'd0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WS;
          end else begin
            w_state_nxt  = ST_RESP;
            w_cnt_nxt    = 4'd0;
            w_enter_resp = 1'b1;
          end
        end else if (w_rsp_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt  = ST_RESP;
          w_cnt_nxt    = 4'd0;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt    = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rst_done <= 1'b1;
    end
  end

  // Request capture on acceptance; later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0000_0000;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  // Response registers: data/err sampled on RESP entry, valid one edge later
  // and dropped on the edge that completes the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'h0000_0000;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= (r_state == ST_RESP) && !w_rsp_done;
      if (w_enter_resp) begin
        r_rdata <= (w_err || w_op_we) ? 32'h0000_0000 : w_load_data;
        r_err   <= w_err;
      end
    end
  end

  // Storage array with per-byte write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_op_we && !w_err) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[w_idx][k*8 +: 8] <= w_wdata_rep[k*8 +: 8];
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule : data_mem_ctrl

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Two controllers (1 and 3 wait states) driven by directed and random
// load/store traffic; expectations come from a byte-array memory model.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  localparam int MEM_SZ = 64;
  localparam int NBYTES = MEM_SZ * 4;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [7:0]  mem_m [2][NBYTES];
  logic [31:0] exp_rd  [2];
  logic        exp_err [2];

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(32), .MEM_SIZE(MEM_SZ), .WAIT_STATES(1)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  data_mem_ctrl #(.ADDR_WIDTH(32), .MEM_SIZE(MEM_SZ), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, access size from funct3, RV32 rules
  function automatic void model(input int d, input bit we, input bit [2:0] f3,
                                input bit [31:0] addr, input bit [31:0] wd,
                                output bit err, output bit [31:0] rd);
    int n;
    int a;
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 0;
    endcase
    rd  = 32'd0;
    err = (n == 0) || (we && f3[2]);
    if (!err) err = (addr % n) != 0;
    if (!err) err = (addr / 4) >= MEM_SZ;
    if (!err) begin
      a = int'(addr);
      if (we) begin
        for (int i = 0; i < n; i++) mem_m[d][a+i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rd = rd | (32'(mem_m[d][a+i]) << (8*i));
        if (!f3[2] && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8*n)) - 32'd1);
      end
    end
  endfunction

  // Present a request, wait for acceptance, scramble inputs, check latency
  // and the response contents against the model.
  task automatic issue(input int d, input bit we, input bit [2:0] f3,
                       input bit [31:0] addr, input bit [31:0] wd, input bit b2b);
    bit e;
    bit [31:0] r;
    bit got;
    int n;
    model(d, we, f3, addr, wd, e, r);
    exp_err[d]    = e;
    exp_rd[d]     = r;
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wd;
    rsp_ready[d]  = b2b;
    if (b2b) begin
      @(negedge clk);
      chk("b2b_ready", 32'(req_ready[d]), 32'd1);
    end else begin
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge clk);
        if (req_ready[d]) got = 1'b1;
        else begin @(posedge clk); #1; end
      end
      if (!got) chk("ready_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    req_valid[d]  = 1'b0;
    rsp_ready[d]  = 1'b0;
    req_we[d]     = 1'($urandom);
    req_funct3[d] = 3'($urandom);
    req_addr[d]   = $urandom;
    req_wdata[d]  = $urandom;
    got = 1'b0;
    n   = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid[d]) got = 1'b1;
    end
    chk("latency", 32'(n), 32'(ws_of(d) + 1));
    chk("rdata", rsp_rdata[d], exp_rd[d]);
    chk("err", 32'(rsp_err[d]), 32'(exp_err[d]));
  endtask

  // Hold rsp_ready low for a while (response must stay put), then consume it
  task automatic release_rsp(input int d, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], exp_rd[d]);
      chk("hold_err", 32'(rsp_err[d]), 32'(exp_err[d]));
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk("rsp_drop", 32'(rsp_valid[d]), 32'd0);
  endtask

  task automatic rand_ops(input int d, input int cnt);
    bit [31:0] a;
    issue(d, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < cnt; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'(NBYTES) + 32'($urandom_range(0, 31));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 2) == 0) begin
        issue(d, 1'($urandom), 3'($urandom), a, $urandom, 1'b1);
      end else begin
        release_rsp(d, $urandom_range(0, 2));
        issue(d, 1'($urandom), 3'($urandom), a, $urandom, 1'b0);
      end
    end
    release_rsp(d, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_err", 32'(rsp_err[d]), 32'd0);
      chk("rst_rdata", rsp_rdata[d], 32'd0);
      chk("rst_ready", 32'(req_ready[d]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    chk("ready_pre_edge", 32'(req_ready[0]), 32'd0);
    @(posedge clk); #1;
    chk("ready_post_edge", 32'(req_ready[0]), 32'd1);

    // Known contents for the first 16 words of each instance
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        issue(d, 1'b1, 3'd2, 32'(w * 4), $urandom, 1'b0);
        release_rsp(d, 0);
      end
    end

    // Directed scenarios, 1 wait state
    issue(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0); release_rsp(0, 0);
    issue(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    chk("lw_deadbeef", rsp_rdata[0], 32'hDEADBEEF);  release_rsp(0, 0);
    issue(0, 1'b1, 3'd0, 32'h11, 32'h80, 1'b0);      release_rsp(0, 0);
    issue(0, 1'b0, 3'd0, 32'h11, 32'h0, 1'b0);
    chk("lb_sext", rsp_rdata[0], 32'hFFFFFF80);      release_rsp(0, 0);
    issue(0, 1'b0, 3'd4, 32'h11, 32'h0, 1'b0);
    chk("lbu_zext", rsp_rdata[0], 32'h00000080);     release_rsp(0, 0);
    issue(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    chk("lw_after_sb", rsp_rdata[0], 32'hDEAD80EF);  release_rsp(0, 0);
    issue(0, 1'b1, 3'd1, 32'h13, 32'h1234, 1'b0);
    chk("sh_misalign_err", 32'(rsp_err[0]), 32'd1);  release_rsp(0, 0);
    issue(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    chk("lw_unchanged", rsp_rdata[0], 32'hDEAD80EF); release_rsp(0, 0);
    issue(0, 1'b0, 3'd2, 32'(NBYTES), 32'h0, 1'b0);
    chk("oob_err", 32'(rsp_err[0]), 32'd1);
    chk("oob_rdata", rsp_rdata[0], 32'd0);           release_rsp(0, 0);
    issue(0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);        release_rsp(0, 0);
    issue(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);       release_rsp(0, 3);
    issue(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    issue(0, 1'b0, 3'd1, 32'h12, 32'h0, 1'b1);
    chk("b2b_lh", rsp_rdata[0], 32'hFFFFDEAD);       release_rsp(0, 0);
    rand_ops(0, 60);

    // Reset during WAIT, 3 wait states: pending store is dropped
    issue(1, 1'b1, 3'd2, 32'h20, 32'h13579BDF, 1'b0); release_rsp(1, 0);
    issue(1, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0);        release_rsp(1, 0);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'd2;
    req_addr[1] = 32'h20; req_wdata[1] = 32'hAAAAAAAA;
    @(negedge clk);
    chk("rst_scn_ready", 32'(req_ready[1]), 32'd1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(rsp_valid[1]), 32'd0);
    chk("midrst_err", 32'(rsp_err[1]), 32'd0);
    chk("midrst_rdata", rsp_rdata[1], 32'd0);
    chk("midrst_ready", 32'(req_ready[1]), 32'd0);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("rel_ready_low", 32'(req_ready[1]), 32'd0);
    @(posedge clk); #1;
    issue(1, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
    chk("old_value_kept", rsp_rdata[1], 32'h13579BDF); release_rsp(1, 0);
    rand_ops(1, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_data_mem_ctrl

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: byte-address width.
REQ-002 Parameter MEM_SIZE, default 256: depth in 32-bit words; power of two, at least 4.
REQ-003 Parameter WAIT_STATES, default 1: extra access cycles, range 0..15.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port req_valid, input, 1: request present.
REQ-007 Port req_ready, output, 1: request accepted this cycle when high together with req_valid.
REQ-008 Port req_we, input, 1: 1 = store, 0 = load.
REQ-009 Port req_funct3, input, 3: RV32 width code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-010 Port req_addr, input, ADDR_WIDTH: byte address.
REQ-011 Port req_wdata, input, 32: store data, right-aligned.
REQ-012 Port rsp_valid, output, 1: response present.
REQ-013 Port rsp_ready, input, 1: consumer accepts the response.
REQ-014 Port rsp_rdata, output, 32: load result, extended per funct3; 0 for stores and errors.
REQ-015 Port rsp_err, output, 1: misaligned, illegal or out-of-range access.

Function
REQ-016 FSM states SHALL be IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be high in IDLE, and in RESP when rsp_ready is high; it SHALL be low otherwise.
REQ-018 On acceptance, the block SHALL latch we, funct3, addr and wdata, and load the wait counter with WAIT_STATES.
REQ-019 State transitions:
- On acceptance, go to WAIT if WAIT_STATES > 0, else to RESP.
- In WAIT, the counter SHALL decrement each cycle; at 1, go to RESP.
REQ-020 Latency: rsp_valid SHALL rise exactly WAIT_STATES+1 cycles after the acceptance edge.
REQ-021 rsp_valid, rsp_rdata and rsp_err SHALL be registered and held stable in RESP until rsp_ready.
REQ-022 On rsp_ready in RESP:
- With a new request accepted the same cycle, continue per REQ-019 (back-to-back, no bubble).
- Otherwise, return to IDLE.
REQ-023 The store commit and the load sample SHALL occur on the edge that enters RESP.
REQ-024 Stores SHALL use a byte-enable write:
- sb writes lane addr[1:0].
- sh writes lanes {addr[1],0} and {addr[1],1}.
- sw writes all four lanes.
- Untouched lanes SHALL be preserved.
REQ-025 Loads:
- lb and lh SHALL sign-extend from bit 7 or bit 15 of the selected lane.
- lbu and lhu SHALL zero-extend.
- lw SHALL return the full word.
REQ-026 Misalignment (h or hu with addr[0]=1; w with addr[1:0]≠0) SHALL set rsp_err and suppress any write.
REQ-027 Illegal funct3 SHALL set rsp_err and suppress any write. Illegal codes are 011, 110 and 111 for loads, and any code other than 000, 001 and 010 for stores.
REQ-028 A word index addr[ADDR_WIDTH-1:2] ≥ MEM_SIZE SHALL set rsp_err; there SHALL be no modulo wrap-around.
REQ-029 The latched request SHALL be immune to input changes after acceptance.

Reset
REQ-030 While rst_n is low:
- The state SHALL be IDLE and the counter 0.
- rsp_valid, rsp_err and rsp_rdata SHALL be 0.
- req_ready SHALL be 0 until the first edge after release.
REQ-031 Reset during WAIT SHALL discard the pending request; an uncommitted store SHALL NOT modify memory.
REQ-032 Memory array contents SHALL NOT be reset.

Structure
REQ-033 Package data_mem_pkg SHALL hold:
- the funct3 constants F3_B, F3_H, F3_W, F3_BU and F3_HU;
- the FSM state type;
- the widths of the lane-select fields.
REQ-034 Sub-module data_mem_align (combinational) SHALL generate byte enables, the replicated store data, the load extract/extend and the misalign/illegal flags.
REQ-035 The storage array SHALL be a 32-bit by MEM_SIZE register array with a per-byte write enable.

Verification
REQ-036 Bench scenarios:
- sw 0xDEADBEEF at 0x10, then lw at 0x10, with WAIT_STATES=1: the lw gives rdata 0xDEADBEEF and err 0, and rsp_valid rises 2 cycles after each acceptance.
- sb 0x80 at 0x11, then lb at 0x11 and lbu at 0x11: the lb gives 0xFFFFFF80 and the lbu gives 0x00000080; a lw at 0x10 then gives 0xDEAD80EF.
- sh 0x1234 at 0x13: err 1; a subsequent lw at 0x10 is unchanged at 0xDEAD80EF.
- lw at byte address MEM_SIZE*4: err 1 and rdata 0; lw at 0x0 is unaffected.
- rsp_ready held low for 3 cycles: rsp_valid and rsp_rdata are held stable. With rsp_ready and a new req_valid in the same cycle, the second request is accepted that cycle and its rsp_valid follows WAIT_STATES+1 cycles later.
- sw 0xAAAAAAAA at 0x20 with WAIT_STATES=3, rst_n pulsed low 1 cycle after acceptance: outputs are 0, and a later lw at 0x20 shows the old value.
